fpadder_feeder: RTL and testbench
=================================

# fpadder_feeder

Operand sequencer and result collector wrapped around the serial single-precision `fpadder`. It accepts operand pairs over a valid/ready interface and buffers them. It drives them onto the adder's shared `a` port in the adder's load_a/load_b cycles, fills idle adder rounds with 0+0 bubbles, and returns only real sums, in order, over a valid/ready output. The feeder sits directly upstream and downstream of `fpadder`, on the same clock and reset net.

## Interface
- `DEPTH`, default 4: operand-pair FIFO entries; must be a power of 2 and at least 2.
- `clock`  in  1: single clock domain, rising edge.
- `nreset`  in  1: reset, asynchronous, active-low. Same net as `fpadder` reset.
- `in_valid`  in  1: an operand pair is offered.
- `in_ready`  out  1: the pair FIFO is not full.
- `in_a`, `in_b`  in  32 each: IEEE-754 single-precision operands.
- `a`  out  32: to `fpadder.a`. Registered.
- `adder_sum`  in  32: from `fpadder.sum`.
- `adder_ready`  in  1: from `fpadder.ready`, a one-cycle pulse.
- `out_valid`  out  1: a real sum is available.
- `out_ready`  in  1: the consumer accepts the sum.
- `out_sum`  out  32: result FIFO head.
- `sync_err`  out  1: sticky protocol error.

## Operation
- Phase FSM states: SYNC, DRIVE_A, DRIVE_B, WAIT_RESULT. Reset state is SYNC.
- SYNC and WAIT_RESULT with `adder_ready`=1 are the "issue" cycle, i.e. the adder's `start` cycle.
- Issue decision, taken in the issue cycle:
  - Real issue if the pair FIFO is non-empty AND (result entries after this edge + in-flight) ≤ 1.
  - Real issue pops the head, loads `a`←A and holds B, and sets `inflight_real`=1.
  - Otherwise it is a bubble: `a`←0, held B←0, `inflight_real`=0.
- Transitions:
  - Issue cycle → DRIVE_A.
  - DRIVE_A → DRIVE_B, with `a`←held B at this edge.
  - DRIVE_B → WAIT_RESULT, with `a`←0.
  - WAIT_RESULT stays until `adder_ready`=1.
- `a` therefore holds A throughout the adder's load_a cycle and B throughout its load_b cycle.
- Result capture: on `adder_ready`=1 in WAIT_RESULT with `inflight_real`=1, push `adder_sum` into the result FIFO (depth 2). Bubble results are discarded.
- Credit scheme: at most 2 results held plus in flight, so a result push never meets a full FIFO.
- `sync_err` is set on `adder_ready`=1 in SYNC, DRIVE_A or DRIVE_B. Only reset clears it. The FSM keeps its normal sequencing after an error.
- Pair FIFO: a simultaneous push and pop is legal at any occupancy. `in_ready`=0 when full; `in_valid` while full is ignored.
- Result FIFO: a simultaneous push and pop is legal. `out_valid`/`out_sum` hold stable while `out_ready`=0.
- Ordering: results leave in pair-push order.

## Timing
- Reset values: `in_ready`=1 (FIFO empty), `a`=0, `out_valid`=0, `out_sum`=0, `sync_err`=0, FSM in SYNC, both FIFOs empty.
- The first cycle after `nreset` deasserts is SYNC, which aligns with the adder's `start`.
- A pair pushed at edge k is issuable from the issue cycle after edge k, never the same cycle.
- The sum appears on `out_valid` one cycle after the `adder_ready` pulse, if the result FIFO was empty.
- Adder round: 6 cycles for 0+0 bubbles; real ops are variable because of the adder's normalize loop. The feeder imposes no fixed latency.
- Reset asserted mid-operation, in any state: all outputs return to reset values immediately and FIFO contents and the in-flight tag are lost. The adder restarts in lockstep.

## Structure
- Package `fpadder_pkg`:
  - `fp32_t` (logic [31:0]).
  - `op_pair_t` struct {a, b}.
  - Phase enum `feed_phase_t`.
  - Constant `FP_ZERO` = 32'h0.
- Sub-module `fp_sync_fifo` (parameters WIDTH, DEPTH), with a count output. Instantiated twice:
  - Pair FIFO, `op_pair_t`, DEPTH.
  - Result FIFO, 32 bits, 2 entries.
- FSM, credit logic and `a` register stay in `fpadder_feeder`.

## Test plan
- Reset, then idle 30 cycles with the real `fpadder` attached → `a`=0 in every cycle, `out_valid`=0, `sync_err`=0, `in_ready`=1.
- Push 1.0+2.0 (0x3F800000, 0x40000000) → `a`=0x3F800000 in DRIVE_A, 0x40000000 in DRIVE_B; `out_sum`=0x40400000, with `out_valid` one cycle after `adder_ready`.
- Push 4 pairs (1.0+1.0, 2.0+2.0, 1.0+2.0, 0+0) with `out_ready`=0:
  - `in_ready` drops at DEPTH occupancy.
  - Exactly 2 results are held and later rounds are bubbles.
  - Release `out_ready` → 0x40000000, 0x40800000, 0x40400000, 0x00000000 in order.
- Continuous `in_valid` with `out_ready`=1 → no bubble issued while the FIFO is non-empty; simultaneous push/pop at full keeps the count constant.
- Adder model pulses `adder_ready` during DRIVE_B → `sync_err`=1 and it stays 1 until reset.
- Assert `nreset` during WAIT_RESULT of a real op and release it → all outputs at reset values; no stale `out_valid`; a fresh pair 1.0+1.0 yields 0x40000000.

Source files
------------

// File: rtl/fpadder_pkg.sv
// Shared types and constants for the fpadder operand feeder.
package fpadder_pkg;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    fp32_t a;
    fp32_t b;
  } op_pair_t;

  typedef enum logic [1:0] {
    SYNC,
    DRIVE_A,
    DRIVE_B,
    WAIT_RESULT
  } feed_phase_t;

  localparam fp32_t FP_ZERO = 32'h0;

endpackage

// File: rtl/fp_sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is accepted only alongside a pop.
module fp_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW + 1)'(DEPTH);
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fpadder_feeder.sv
// Operand sequencer / result collector for the serial fpadder: issues real pairs or
// 0+0 bubbles each adder round and returns only real sums, in order.
module fpadder_feeder
  import fpadder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] a,
  input  logic [31:0] adder_sum,
  input  logic        adder_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        sync_err
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  feed_phase_t   phase;
  fp32_t         held_b;
  logic          inflight_real;
  op_pair_t      in_pair;
  op_pair_t      pair_head;
  logic [PW-1:0] pair_count;
  logic [1:0]    res_count;
  logic [1:0]    res_after;
  logic          pair_push;
  logic          issue;
  logic          real_issue;
  logic          res_push;
  logic          res_pop;

  assign in_pair   = '{a: in_a, b: in_b};
  assign in_ready  = pair_count != PW'(DEPTH);
  assign pair_push = in_valid && in_ready;
  assign out_valid = res_count != '0;

  // Credit: results held after this edge plus the new issue must not exceed the 2-entry result FIFO.
  always_comb begin
    issue      = (phase == SYNC) || ((phase == WAIT_RESULT) && adder_ready);
    res_push   = (phase == WAIT_RESULT) && adder_ready && inflight_real;
    res_pop    = out_valid && out_ready;
    res_after  = res_count + {1'b0, res_push} - {1'b0, res_pop};
    real_issue = issue && (pair_count != '0) && (res_after <= 2'd1);
  end

  fp_sync_fifo #(
    .WIDTH ($bits(op_pair_t)),
    .DEPTH (DEPTH)
  ) u_pair_fifo (
    .clock     (clock),
    .nreset    (nreset),
    .push      (pair_push),
    .push_data (in_pair),
    .pop       (real_issue),
    .head      (pair_head),
    .count     (pair_count)
  );

  fp_sync_fifo #(
    .WIDTH (32),
    .DEPTH (2)
  ) u_res_fifo (
    .clock     (clock),
    .nreset    (nreset),
    .push      (res_push),
    .push_data (adder_sum),
    .pop       (res_pop),
    .head      (out_sum),
    .count     (res_count)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      phase         <= SYNC;
      a             <= FP_ZERO;
      held_b        <= FP_ZERO;
      inflight_real <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      if (adder_ready && (phase != WAIT_RESULT)) sync_err <= 1'b1;
      case (phase)
        SYNC, WAIT_RESULT: begin
          if (issue) begin
            phase         <= DRIVE_A;
            inflight_real <= real_issue;
            if (real_issue) begin
              a      <= pair_head.a;
              held_b <= pair_head.b;
            end else begin
              a      <= FP_ZERO;
              held_b <= FP_ZERO;
            end
          end
        end
        DRIVE_A: begin
          a     <= held_b;
          phase <= DRIVE_B;
        end
        DRIVE_B: begin
          a     <= FP_ZERO;
          phase <= WAIT_RESULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpadder_feeder.sv
// Bench for fpadder_feeder with a behavioural serial-adder model and an in-order scoreboard.
module tb_fpadder_feeder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  typedef enum {M_START, M_LA, M_LB, M_CALC} mph_t;

  logic        clock = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] a;
  logic [31:0] adder_sum;
  logic        adder_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        sync_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] drv_exp;
  int          push_cnt = 0;
  int          real_cnt = 0;
  int          snap_avail = 0;
  int          base4 = 0;
  logic        stream_chk = 1'b0;
  logic        inject_early = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [31:0] last_real_a = '0;
  logic [31:0] last_real_b = '0;
  mph_t        mph;
  int          calc_left;
  vec_t        vecs[6];

  fpadder_feeder #(.DEPTH(4)) dut (
    .clock       (clock),
    .nreset      (nreset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .a           (a),
    .adder_sum   (adder_sum),
    .adder_ready (adder_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .sync_err    (sync_err)
  );

  always #5 clock = ~clock;

  // Exact for positive normals whose sum needs no rounding (the values used here).
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [7:0]  ex, ey;
    logic [24:0] mx, my, m;
    logic [31:0] t;
    if (x[30:0] == 31'd0) return y;
    if (y[30:0] == 31'd0) return x;
    if (x[30:23] < y[30:23]) begin t = x; x = y; y = t; end
    ex = x[30:23];
    ey = y[30:23];
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]} >> (ex - ey);
    m  = mx + my;
    if (m[24]) begin m = m >> 1; ex = ex + 8'd1; end
    return {1'b0, ex, m[22:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Serial adder model: start, load_a, load_b, compute, ready pulse coinciding with next start.
  initial begin
    logic rs;
    mph = M_START; adder_ready = 1'b0; adder_sum = '0; calc_left = 0;
    forever begin
      @(posedge clock);
      rs = nreset;
      #1;
      adder_ready = 1'b0;
      if (!rs) mph = M_START;
      else begin
        case (mph)
          M_START: mph = M_LA;
          M_LA: begin
            mph = M_LB;
            if (inject_early) adder_ready = 1'b1;
          end
          M_LB: begin
            mph = M_CALC;
            calc_left = (opa == 0 && opb == 0) ? 3 : 3 + int'($urandom_range(0, 4));
          end
          M_CALC: begin
            calc_left--;
            if (calc_left == 0) begin
              mph = M_START;
              adder_ready = 1'b1;
              adder_sum = fp_add(opa, opb);
            end
          end
        endcase
      end
    end
  end

  // Operand sampling, bubble-while-pending check and scoreboard, all at the inactive edge.
  always @(negedge clock) begin
    if (mph == M_START) snap_avail = push_cnt - real_cnt - base4;
    if (mph == M_LA) opa = a;
    if (mph == M_LB) begin
      opb = a;
      if (opa != 0 || opb != 0) begin
        real_cnt++;
        last_real_a = opa;
        last_real_b = opb;
      end else if (stream_chk && snap_avail > 0) begin
        chk("no_bubble_while_pending", 64'(snap_avail), 64'd0);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(drv_exp);
      push_cnt++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", {32'd0, out_sum}, 64'hDEAD);
      else chk("out_sum_order", {32'd0, out_sum}, {32'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic push_pair(input logic [31:0] pa, input logic [31:0] pb, input logic [31:0] pe);
    logic ok;
    int   n;
    in_a = pa; in_b = pb; drv_exp = pe; in_valid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 500) begin
      @(negedge clock);
      ok = in_ready;
      step();
      n++;
    end
    if (!ok) chk("push_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    step();
  endtask

  initial begin
    int   n;
    logic found;
    logic [31:0] vals[3];
    logic [31:0] ra, rb;
    int   base3;

    vecs[0] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
    vecs[1] = '{32'h40000000, 32'h40000000, 32'h40800000};
    vecs[2] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    vecs[3] = '{32'h00000000, 32'h00000000, 32'h00000000};
    vecs[4] = '{32'h40800000, 32'h40800000, 32'h41000000};
    vecs[5] = '{32'h3F800000, 32'h40800000, 32'h40A00000};
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40800000;

    nreset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; drv_exp = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_a_sum", {a, out_sum}, 64'd0);
    chk("reset_flags", {61'd0, in_ready, out_valid, sync_err}, 64'd4);
    nreset = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      chk("idle", {a, 29'd0, out_valid, sync_err, in_ready}, 64'd1);
    end

    // Single pair 1.0 + 2.0, result one cycle after the adder pulse.
    step();
    out_ready = 1'b1;
    push_pair(vecs[2].a, vecs[2].b, vecs[2].sum);
    found = 1'b0; n = 0;
    while (!found && n < 200) begin
      @(negedge clock);
      if (adder_ready && adder_sum == 32'h40400000) found = 1'b1;
      n++;
    end
    chk("single_ready_seen", {63'd0, found}, 64'd1);
    chk("single_valid_at_pulse", {63'd0, out_valid}, 64'd0);
    @(negedge clock);
    chk("single_valid_after", {63'd0, out_valid}, 64'd1);
    chk("single_sum", {32'd0, out_sum}, 64'h40400000);
    chk("single_drive_ab", {last_real_a, last_real_b}, {32'h3F800000, 32'h40000000});
    wait_drain("single");

    // Backpressure: two results held, the rest queued, later rounds bubbles.
    out_ready = 1'b0;
    base3 = real_cnt;
    for (int i = 0; i < 6; i++) push_pair(vecs[i].a, vecs[i].b, vecs[i].sum);
    repeat (40) @(negedge clock);
    chk("held_real_rounds", 64'(real_cnt - base3), 64'd2);
    chk("held_in_ready", {63'd0, in_ready}, 64'd0);
    chk("held_out", {31'd0, out_valid, out_sum}, {31'd0, 1'b1, 32'h40000000});
    step();
    out_ready = 1'b1;
    wait_drain("backpressure");

    // Continuous stream: a pending pair must never lose its round to a bubble.
    base4 = push_cnt - real_cnt;
    stream_chk = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ra = vals[$urandom_range(0, 2)];
      rb = vals[$urandom_range(0, 2)];
      push_pair(ra, rb, fp_add(ra, rb));
    end
    wait_drain("stream");
    stream_chk = 1'b0;

    // Early adder pulse sets the sticky error.
    inject_early = 1'b1;
    found = 1'b0; n = 0;
    while (!found && n < 50) begin
      @(negedge clock);
      found = sync_err;
      n++;
    end
    chk("sync_err_set", {63'd0, found}, 64'd1);
    step();
    inject_early = 1'b0;
    repeat (20) @(negedge clock);
    chk("sync_err_sticky", {63'd0, sync_err}, 64'd1);

    // Reset during WAIT_RESULT of a real op.
    step();
    out_ready = 1'b0;
    push_pair(32'h3F800000, 32'h3F800000, 32'h40000000);
    found = 1'b0; n = 0;
    while (!found && n < 100) begin
      @(negedge clock);
      found = (mph == M_CALC) && (opa == 32'h3F800000);
      n++;
    end
    chk("midop_reached", {63'd0, found}, 64'd1);
    nreset = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_a_sum", {a, out_sum}, 64'd0);
    chk("midreset_flags", {61'd0, in_ready, out_valid, sync_err}, 64'd4);
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("post_reset_quiet", {62'd0, out_valid, sync_err}, 64'd0);
    end
    step();
    out_ready = 1'b1;
    push_pair(32'h3F800000, 32'h3F800000, 32'h40000000);
    wait_drain("post_reset");

    repeat (5) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
